// File: rtl/fifo_reader.sv
// Pops words from an upstream FIFO one at a time and presents each on a registered
// valid/ready output, counting every word the downstream consumer accepts.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   IDLE    | no pop outstanding; waiting for pop permission
//   REQ     | rd_en asserted for this single cycle
//   CAPTURE | FIFO read data is valid; loaded into data_out at closing edge
//   HOLD    | word presented (valid_out=1) until ready_in accepts it
module fifo_reader #(
    parameter int DATA_WIDTH = 4,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  almostEmpty,
    input  logic [3:0]            fifo_counter,
    input  logic [DATA_WIDTH-1:0] DataOut,
    output logic                  rd_en,
    input  logic                  flush,
    input  logic                  ready_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  valid_out,
    output logic                  busy,
    output logic [CNT_WIDTH-1:0]  pop_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;
    logic                  valid_q, valid_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  armed_q;
    logic                  can_pop;

    // Flush lets the FIFO drain past the almost-empty mark, all the way to zero.
    assign can_pop = flush ? (fifo_counter != 4'd0) : !almostEmpty;

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                // armed_q holds off the first pop until one clean edge after reset.
                if (armed_q && can_pop) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                data_d  = DataOut;
                valid_d = 1'b1;
                state_d = HOLD;
            end
            HOLD: begin
                if (ready_in) begin
                    valid_d = 1'b0;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = can_pop ? REQ : IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            data_q  <= '0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
            armed_q <= 1'b1;
        end
    end

    assign rd_en     = (state_q == REQ);
    assign busy      = (state_q != IDLE);
    assign data_out  = data_q;
    assign valid_out = valid_q;
    assign pop_count = cnt_q;

endmodule

// File: tb/tb_fifo_reader.sv
// Randomised and directed stimulus for fifo_reader, checked every cycle against a
// transaction-level model that tracks when each pop was issued and its word landed.
module tb_fifo_reader;

    logic       clk = 1'b0;
    logic       rst_v;
    logic       ae;
    logic [3:0] fcnt;
    logic [3:0] dout;
    logic       flush_v;
    logic       rdy;
    logic       rd_en;
    logic [3:0] data_out;
    logic       valid_out;
    logic       busy;
    logic [7:0] pop_count;

    fifo_reader #(.DATA_WIDTH(4), .CNT_WIDTH(8)) dut (
        .clk          (clk),
        .rst          (rst_v),
        .almostEmpty  (ae),
        .fifo_counter (fcnt),
        .DataOut      (dout),
        .rd_en        (rd_en),
        .flush        (flush_v),
        .ready_in     (rdy),
        .data_out     (data_out),
        .valid_out    (valid_out),
        .busy         (busy),
        .pop_count    (pop_count)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // model: a word either sits at the output (m_vld) or is in flight since edge m_issue
    logic       m_vld;
    logic [3:0] m_data;
    logic [7:0] m_cnt;
    int         m_issue;
    int         m_edge;
    logic       m_armed;

    logic       emul;
    logic [3:0] q[$];
    logic [3:0] cons_q[$];
    int         rd_cyc[$];
    int         rd_cnt;
    int         cons_cnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic model_step();
        logic can;
        if (!rst_v) begin
            m_vld   = 1'b0;
            m_data  = 4'd0;
            m_cnt   = 8'd0;
            m_issue = -1;
            m_armed = 1'b0;
        end else begin
            can = flush_v ? (fcnt != 4'd0) : !ae;
            if (m_vld) begin
                if (rdy) begin
                    m_cnt = m_cnt + 8'd1;
                    m_vld = 1'b0;
                    if (can) m_issue = m_edge;
                end
            end else if (m_issue >= 0) begin
                if (m_edge == m_issue + 2) begin
                    m_data  = dout;
                    m_vld   = 1'b1;
                    m_issue = -1;
                end
            end else if (m_armed && can) begin
                m_issue = m_edge;
            end
            m_armed = 1'b1;
        end
        m_edge++;
    endtask

    task automatic cycle();
        logic rd_seen;
        @(negedge clk);
        chk("rd_en", {31'd0, rd_en}, {31'd0, (m_issue >= 0) && (m_edge == m_issue + 1)});
        chk("valid_out", {31'd0, valid_out}, {31'd0, m_vld});
        chk("data_out", {28'd0, data_out}, {28'd0, m_data});
        chk("pop_count", {24'd0, pop_count}, {24'd0, m_cnt});
        chk("busy", {31'd0, busy}, {31'd0, m_vld || (m_issue >= 0)});
        rd_seen = rd_en && rst_v;
        if (rd_seen) begin
            rd_cnt++;
            rd_cyc.push_back(cyc);
        end
        if (rst_v && valid_out && rdy) begin
            cons_cnt++;
            cons_q.push_back(data_out);
        end
        @(posedge clk);
        model_step();
        #1;
        if (emul && rd_seen) begin
            if (fcnt != 4'd0) fcnt = fcnt - 4'd1;
            if (q.size() > 0) dout = q.pop_front();
        end
        cyc++;
    endtask

    task automatic do_reset();
        rst_v = 1'b0;
        cycle();
        cycle();
        rst_v = 1'b1;
        q.delete();
        cons_q.delete();
        rd_cyc.delete();
        rd_cnt   = 0;
        cons_cnt = 0;
    endtask

    initial begin
        int n;
        rst_v = 1'b0; ae = 1'b1; fcnt = 4'd0; dout = 4'd0; flush_v = 1'b0; rdy = 1'b0;
        emul = 1'b1; m_edge = 0;
        repeat (2) @(posedge clk);
        #1;
        m_vld = 1'b0; m_data = 4'd0; m_cnt = 8'd0; m_issue = -1; m_armed = 1'b0;

        // reset state
        do_reset();
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_cnt", {24'd0, pop_count}, 32'd0);

        // basic pop of 5
        q.push_back(4'h5);
        ae = 1'b0; rdy = 1'b1;
        n = 0;
        while (rd_cnt == 0 && n < 10) begin cycle(); n++; end
        chk("basic_rd_seen", rd_cnt, 1);
        ae = 1'b1;
        repeat (4) cycle();
        chk("basic_cnt", {24'd0, pop_count}, 32'd1);
        chk("basic_data", cons_q.size() > 0 ? {28'd0, cons_q[0]} : 32'hdead, 32'h5);

        // backpressure with A held for 5 cycles
        do_reset();
        q.push_back(4'hA);
        ae = 1'b0; rdy = 1'b0;
        n = 0;
        while (!(valid_out === 1'b1) && n < 10) begin
            cycle(); n++;
            if (rd_cnt > 0) ae = 1'b1;
        end
        chk("bp_valid_seen", {31'd0, valid_out}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("bp_data", {28'd0, data_out}, 32'hA);
            chk("bp_valid", {31'd0, valid_out}, 32'd1);
            chk("bp_rd", {31'd0, rd_en}, 32'd0);
        end
        rdy = 1'b1;
        cycle();
        chk("bp_cnt", {24'd0, pop_count}, 32'd1);
        repeat (3) cycle();
        chk("bp_cnt_once", {24'd0, pop_count}, 32'd1);

        // almost-empty stall, then flush drains two words
        do_reset();
        ae = 1'b1; flush_v = 1'b0; fcnt = 4'd2; rdy = 1'b1;
        q.push_back(4'h7); q.push_back(4'h8);
        repeat (8) cycle();
        chk("stall_rd", rd_cnt, 0);
        flush_v = 1'b1;
        repeat (20) cycle();
        chk("flush_pops", rd_cnt, 2);
        chk("flush_idle", {31'd0, busy}, 32'd0);
        chk("flush_fcnt", {28'd0, fcnt}, 32'd0);
        chk("flush_cnt", {24'd0, pop_count}, 32'd2);
        flush_v = 1'b0;

        // streaming 1,2,3,4
        do_reset();
        for (int i = 1; i <= 4; i++) q.push_back(4'(i));
        fcnt = 4'd8; ae = 1'b0; rdy = 1'b1;
        n = 0;
        while (cons_cnt < 4 && n < 40) begin
            cycle(); n++;
            if (rd_cnt >= 4) ae = 1'b1;
        end
        repeat (2) cycle();
        chk("stream_cons", cons_cnt, 4);
        for (int i = 0; i < 4; i++)
            chk("stream_data", i < cons_q.size() ? {28'd0, cons_q[i]} : 32'hdead, i + 1);
        for (int i = 1; i < 4; i++)
            chk("stream_gap", i < rd_cyc.size() ? rd_cyc[i] - rd_cyc[i-1] : -1, 3);
        chk("stream_cnt", {24'd0, pop_count}, 32'd4);

        // reset during HOLD with pop_count=3
        do_reset();
        emul = 1'b0;
        ae = 1'b0; rdy = 1'b1;
        n = 0;
        while (cons_cnt < 3 && n < 30) begin dout = 4'($urandom); cycle(); n++; end
        rdy = 1'b0; ae = 1'b1;
        n = 0;
        while (!(valid_out === 1'b1) && n < 10) begin dout = 4'($urandom_range(1, 15)); cycle(); n++; end
        chk("mid_cnt3", {24'd0, pop_count}, 32'd3);
        chk("mid_valid", {31'd0, valid_out}, 32'd1);
        rst_v = 1'b0;
        cycle();
        chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
        chk("mid_rst_data", {28'd0, data_out}, 32'd0);
        chk("mid_rst_cnt", {24'd0, pop_count}, 32'd0);
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        rst_v = 1'b1;

        // 256 consumed words wrap the counter
        do_reset();
        ae = 1'b0; rdy = 1'b1;
        n = 0;
        while (cons_cnt < 256 && n < 1000) begin dout = 4'($urandom); cycle(); n++; end
        ae = 1'b1; rdy = 1'b0;
        repeat (3) cycle();
        chk("wrap_cons", cons_cnt, 256);
        chk("wrap_cnt", {24'd0, pop_count}, 32'd0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            rst_v   = ($urandom_range(0, 60) != 0);
            ae      = ($urandom_range(0, 2) == 0);
            flush_v = ($urandom_range(0, 3) == 0);
            fcnt    = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom);
            rdy     = $urandom_range(0, 1) == 1;
            dout    = 4'($urandom);
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_reader.md
FIFO_READER -- requirements
Module: fifo_reader

Interface
REQ-001 Parameter DATA_WIDTH, 4, width of FIFO data and output word.
REQ-002 Parameter CNT_WIDTH, 8, width of the pop_count statistics counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-low (0 = reset, sampled on clk rising edge).
REQ-005 Port almostEmpty  input  1  FIFO almost-empty flag.
REQ-006 Port fifo_counter  input  4  FIFO occupancy.
REQ-007 Port DataOut  input  DATA_WIDTH  FIFO read data; valid in the cycle after the edge that sampled rd_en=1.
REQ-008 Port rd_en  output  1  FIFO pop request, one cycle per pop.
REQ-009 Port flush  input  1  drain mode; allows popping below the almost-empty mark down to zero occupancy.
REQ-010 Port ready_in  input  1  downstream consumer accepts the word when ready_in=1 and valid_out=1.
REQ-011 Port data_out  output  DATA_WIDTH  registered word to downstream.
REQ-012 Port valid_out  output  1  data_out holds an unconsumed word.
REQ-013 Port busy  output  1  high in any state other than IDLE.
REQ-014 Port pop_count  output  CNT_WIDTH  number of words delivered downstream since reset.

Function
REQ-015 The block SHALL implement a four-state FSM: IDLE, REQ, CAPTURE, HOLD.
REQ-016 Pop permission (can_pop) SHALL be (!almostEmpty) when flush=0, and (fifo_counter != 0) when flush=1.
REQ-017 IDLE: if can_pop, next state SHALL be REQ; otherwise stay in IDLE.
REQ-018 REQ: rd_en SHALL be 1 for exactly this one cycle; next state SHALL be CAPTURE unconditionally.
REQ-019 CAPTURE: data_out SHALL load DataOut at the closing edge; valid_out SHALL rise at that edge; next state SHALL be HOLD.
REQ-020 HOLD: data_out and valid_out SHALL stay stable while ready_in=0.
REQ-021 HOLD with ready_in=1: the word is consumed, pop_count SHALL increment by 1 at that edge, and valid_out SHALL clear.
- Next state SHALL be REQ if can_pop, else IDLE (back-to-back rate: one word per 3 cycles).
REQ-022 rd_en SHALL be 0 in every state except REQ; never two consecutive cycles of rd_en=1.
REQ-023 can_pop SHALL be evaluated only in IDLE and on the consuming HOLD cycle; a change of almostEmpty or flush during REQ/CAPTURE SHALL NOT cancel a pop already issued.
REQ-024 pop_count SHALL wrap modulo 2^CNT_WIDTH (255 -> 0) with no saturation.
REQ-025 busy SHALL equal (state != IDLE).
REQ-026 ready_in SHALL be ignored when valid_out=0; no count or state effect.

Reset
REQ-027 While rst=0 at a rising edge, the block SHALL enter IDLE and set rd_en=0, valid_out=0, data_out=0, pop_count=0, busy=0.
REQ-028 Reset SHALL take priority over all other inputs, including mid-transaction (REQ/CAPTURE/HOLD); a pending word SHALL be discarded without incrementing pop_count.
REQ-029 The first pop after reset release SHALL be requested no earlier than the second rising edge with rst=1.

Verification
REQ-030 Basic pop: almostEmpty=0, DataOut=4'h5 in CAPTURE, ready_in=1 -> rd_en high for 1 cycle, valid_out=1 with data_out=5 two cycles after REQ entry, pop_count=1.
REQ-031 Backpressure: ready_in=0 for 5 cycles in HOLD with data_out=4'hA -> data_out stays A, valid_out stays 1, rd_en stays 0; ready_in=1 -> pop_count increments once.
REQ-032 Almost-empty stall: almostEmpty=1, flush=0, fifo_counter=2 -> remains IDLE, rd_en never asserted; set flush=1 -> exactly 2 pops, then IDLE once fifo_counter=0.
REQ-033 Streaming: almostEmpty=0 held, ready_in=1 held, 4 words 1,2,3,4 -> rd_en pulses every 3 cycles, data_out sequence 1,2,3,4, pop_count=4.
REQ-034 Reset mid-operation: rst=0 during HOLD with valid_out=1, pop_count=3 -> next edge valid_out=0, data_out=0, pop_count=0, state IDLE.
REQ-035 Wrap: 256 consumed words -> pop_count returns to 0.
